// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources.
// It launches one frame at a time and follows TX_Busy until that frame has finished.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            Req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
    input  logic [NUM_REQ-1:0]            Req_Par_En,
    output logic [NUM_REQ-1:0]            Ack,
    output logic [NUM_REQ-1:0]            Done,
    output logic                          Timeout_Err,
    output logic                          TX_Data_Valid,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic                          TX_Parity_Enable,
    input  logic                          TX_Busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       sel;
    logic [PTR_W-1:0]       ptr_after_sel;
    logic [PTR_W-1:0]       winner;
    logic [PTR_W:0]         cand_sum;
    logic                   found;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   par_q;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_REQ-1:0]     done_q;
    logic                   tout_q;
    logic                   grant;
    logic                   finish_done;
    logic                   finish_tout;
    logic                   cnt_inc;

    // Search for the first pending request at or after ptr, wrapping past the top index
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(NUM_REQ))
                cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
            if (!found && Req[cand_sum[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand_sum[PTR_W-1:0];
            end
        end
    end

    assign ptr_after_sel = (sel == PTR_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Holding off while TX_Busy is high keeps a launch from landing in the transmitter's stop bit
    always_comb begin
        state_next    = state;
        grant         = 1'b0;
        finish_done   = 1'b0;
        finish_tout   = 1'b0;
        cnt_inc       = 1'b0;
        TX_Data_Valid = 1'b0;
        Ack           = '0;
        case (state)
            IDLE: begin
                if (found && !TX_Busy) begin
                    grant      = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                TX_Data_Valid = 1'b1;
                Ack[sel]      = 1'b1;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_Busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT-1)) begin
                    finish_tout = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!TX_Busy) begin
                    finish_done = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr    <= '0;
            sel    <= '0;
            data_q <= '0;
            par_q  <= 1'b0;
            cnt    <= '0;
            done_q <= '0;
            tout_q <= 1'b0;
        end else begin
            done_q <= '0;
            tout_q <= 1'b0;
            if (grant) begin
                sel    <= winner;
                data_q <= Req_Data[winner*DATA_WIDTH +: DATA_WIDTH];
                par_q  <= Req_Par_En[winner];
            end
            if (state == LAUNCH)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (finish_done) begin
                done_q[sel] <= 1'b1;
                ptr         <= ptr_after_sel;
            end
            if (finish_tout) begin
                tout_q <= 1'b1;
                ptr    <= ptr_after_sel;
            end
        end
    end

    assign Done             = done_q;
    assign Timeout_Err      = tout_q;
    assign TX_P_DATA        = data_q;
    assign TX_Parity_Enable = par_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by random traffic. A frame-level
// reference model predicts every launch, Ack, Done and timeout, and the byte on the bus.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int T  = 8;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic [N-1:0]    Req = '0;
   logic [N*DW-1:0] Req_Data = '0;
   logic [N-1:0]    Req_Par_En = '0;
   logic [N-1:0]    Ack;
   logic [N-1:0]    Done;
   logic            Timeout_Err;
   logic            TX_Data_Valid;
   logic [DW-1:0]   TX_P_DATA;
   logic            TX_Parity_Enable;
   logic            TX_Busy;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(T)) dut (
      .CLK(CLK), .RST(RST), .Req(Req), .Req_Data(Req_Data), .Req_Par_En(Req_Par_En),
      .Ack(Ack), .Done(Done), .Timeout_Err(Timeout_Err), .TX_Data_Valid(TX_Data_Valid),
      .TX_P_DATA(TX_P_DATA), .TX_Parity_Enable(TX_Parity_Enable), .TX_Busy(TX_Busy)
   );

   // Free-running clock, 10 time units per cycle
   always #5 CLK = ~CLK;

   // Transmitter stand-in: Busy rises cfgD cycles after a launch and stays high cfgH cycles
   int  cfgD = 2;
   int  cfgH = 10;
   bit  cfgEn = 1'b1;
   int  bmPhase = 0;
   int  bmD = 2;
   int  bmH = 10;
   bit  bmActive = 1'b0;

   assign TX_Busy = bmActive && (bmPhase >= bmD) && (bmPhase <= bmD + bmH - 1);

   always @(posedge CLK) begin
      if (RST) begin
         bmActive <= 1'b0;
         bmPhase  <= 0;
      end else if (TX_Data_Valid) begin
         bmActive <= cfgEn;
         bmPhase  <= 1;
         bmD      <= cfgD;
         bmH      <= cfgH;
      end else if (bmActive) begin
         if (bmPhase >= bmD + bmH - 1)
            bmActive <= 1'b0;
         bmPhase <= bmPhase + 1;
      end
   end

   // Reference model state, expressed as cycle numbers of upcoming frame events
   int           mCyc = 0;
   int           mPtr = 0;
   int           mSel = 0;
   int           mLaunch = -1;
   int           mEnd = -1;
   int           mFree = 1;
   bit           mTout = 1'b0;
   logic [DW-1:0] mData = '0;
   logic         mPar = 1'b0;
   logic [DW-1:0] mPendData = '0;
   logic         mPendPar = 1'b0;
   logic [DW-1:0] launched[$];
   int           doneCnt = 0;
   int           toutCnt = 0;
   logic [N-1:0] lastAck = '0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, mCyc);
      end
   endtask

   function automatic logic [31:0] launchedAt(input int idx);
      if (idx < launched.size())
         return {24'h0, launched[idx]};
      return 32'hDEAD;
   endfunction

   // One model cycle, evaluated at the falling edge
   task automatic modelStep();
      logic         expValid;
      logic         expTo;
      logic [N-1:0] expAck;
      logic [N-1:0] expDone;
      bit           hit;
      int           idx;
      mCyc++;
      if (mCyc == mLaunch) begin
         mData = mPendData;
         mPar  = mPendPar;
         mTout = !cfgEn;
         mEnd  = cfgEn ? mLaunch + cfgD + cfgH + 1 : mLaunch + T + 1;
         mFree = mEnd;
         mPtr  = (mSel + 1) % N;
      end
      expValid = (mCyc == mLaunch);
      expAck   = expValid ? N'(1 << mSel) : '0;
      expDone  = (mCyc == mEnd && !mTout) ? N'(1 << mSel) : '0;
      expTo    = (mCyc == mEnd && mTout);
      checkOutput("valid", 32'(TX_Data_Valid), 32'(expValid));
      checkOutput("ack", 32'(Ack), 32'(expAck));
      checkOutput("done", 32'(Done), 32'(expDone));
      checkOutput("timeout", 32'(Timeout_Err), 32'(expTo));
      checkOutput("data", 32'(TX_P_DATA), 32'(mData));
      checkOutput("parity", 32'(TX_Parity_Enable), 32'(mPar));
      checkOutput("valid_while_busy", 32'(TX_Data_Valid & TX_Busy), 32'h0);
      if (TX_Data_Valid) launched.push_back(TX_P_DATA);
      if (Done != '0) doneCnt++;
      if (Timeout_Err) toutCnt++;
      lastAck = Ack;
      if (RST) begin
         mPtr = 0; mData = '0; mPar = 1'b0;
         mLaunch = -1; mEnd = -1; mFree = mCyc + 1;
      end else if (mCyc == mFree) begin
         mFree = mCyc + 1;
         hit = 1'b0;
         for (int k = 0; k < N; k++) begin
            idx = (mPtr + k) % N;
            if (!hit && Req[idx]) begin
               hit       = 1'b1;
               mSel      = idx;
               mPendData = Req_Data[idx*DW +: DW];
               mPendPar  = Req_Par_En[idx];
               mLaunch   = mCyc + 1;
               mFree     = -1;
            end
         end
      end
   endtask

   // Advance n cycles, running the model at each falling edge; returns just after a rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK);
         modelStep();
         @(posedge CLK);
      end
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] req, input logic [N*DW-1:0] data, input logic [N-1:0] par);
      Req        = req;
      Req_Data   = data;
      Req_Par_En = par;
   endtask

   task automatic pulseReset();
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
   endtask

   initial begin
      int base;
      int d0;
      int t0;
      logic [DW-1:0] rrExp[5];
      logic [DW-1:0] wrapExp[4];
      rrExp   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      wrapExp = '{8'h33, 8'h40, 8'h33, 8'h40};

      tick(3);
      RST = 1'b0;
      tick(2);

      // Single request from requester 0
      base = launched.size();
      applyStimulus(4'b0001, 32'h0000_00A5, 4'b0001);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(16);
      checkOutput("single_count", 32'(launched.size() - base), 32'd1);
      checkOutput("single_byte", launchedAt(base), 32'hA5);

      // All four requesting: strict rotation from requester 0
      pulseReset();
      base = launched.size();
      applyStimulus(4'b1111, 32'h1312_1110, 4'b0101);
      tick(70);
      applyStimulus('0, '0, '0);
      tick(20);
      for (int i = 0; i < 5; i++)
         checkOutput("rr_order", launchedAt(base + i), 32'(rrExp[i]));

      // Wrap from requester 3 back to 0 with 0 and 3 both pending
      pulseReset();
      base = launched.size();
      applyStimulus(4'b1000, 32'h3300_0000, 4'b0000);
      tick(1);
      applyStimulus(4'b1001, 32'h3300_0040, 4'b1000);
      tick(50);
      applyStimulus('0, '0, '0);
      tick(20);
      for (int i = 0; i < 4; i++)
         checkOutput("wrap_order", launchedAt(base + i), 32'(wrapExp[i]));

      // Transmitter never goes busy: timeout, then a normal frame
      cfgEn = 1'b0;
      d0 = doneCnt; t0 = toutCnt;
      applyStimulus(4'b0001, 32'h0000_0077, 4'b0000);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(15);
      checkOutput("timeout_pulses", 32'(toutCnt - t0), 32'd1);
      checkOutput("timeout_no_done", 32'(doneCnt - d0), 32'd0);
      cfgEn = 1'b1;
      d0 = doneCnt;
      applyStimulus(4'b0010, 32'h0000_8800, 4'b0010);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(16);
      checkOutput("after_timeout_byte", launchedAt(launched.size() - 1), 32'h88);
      checkOutput("after_timeout_done", 32'(doneCnt - d0), 32'd1);

      // Busy rising on the last allowed cycle is not a timeout
      cfgD = T;
      d0 = doneCnt; t0 = toutCnt;
      applyStimulus(4'b0100, 32'h0066_0000, 4'b0000);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(25);
      checkOutput("late_busy_tout", 32'(toutCnt - t0), 32'd0);
      checkOutput("late_busy_done", 32'(doneCnt - d0), 32'd1);
      cfgD = 2;

      // Reset while the frame is in WAIT_DONE
      d0 = doneCnt;
      applyStimulus(4'b0001, 32'h0000_00C3, 4'b0001);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(5);
      pulseReset();
      checkOutput("rst_valid", 32'(TX_Data_Valid), 32'h0);
      checkOutput("rst_ack", 32'(Ack), 32'h0);
      checkOutput("rst_done", 32'(Done), 32'h0);
      checkOutput("rst_data", 32'(TX_P_DATA), 32'h0);
      checkOutput("rst_par", 32'(TX_Parity_Enable), 32'h0);
      tick(15);
      checkOutput("rst_no_done", 32'(doneCnt - d0), 32'd0);
      applyStimulus(4'b0100, 32'h005C_0000, 4'b0000);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(16);
      checkOutput("rst_then_req2", launchedAt(launched.size() - 1), 32'h5C);

      // Request from 1 pulsed for a single cycle mid-frame is never served
      applyStimulus(4'b0001, 32'h0000_0021, 4'b0000);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(4);
      base = launched.size();
      applyStimulus(4'b0010, 32'h0000_9900, 4'b0010);
      tick(1);
      applyStimulus('0, '0, '0);
      tick(30);
      checkOutput("withdrawn", 32'(launched.size() - base), 32'd0);

      // Random traffic with randomized transmitter timing and occasional resets
      for (int c = 0; c < 3000; c++) begin
         if (c % 16 == 0) begin
            cfgEn = ($urandom % 10) != 0;
            cfgD  = $urandom_range(1, T);
            cfgH  = $urandom_range(1, 12);
         end
         RST = ($urandom % 700) == 0;
         for (int i = 0; i < N; i++) begin
            if (Req[i] && lastAck[i]) begin
               Req[i]              = 1'($urandom % 2);
               Req_Data[i*DW +: DW] = DW'($urandom);
               Req_Par_En[i]       = 1'($urandom % 2);
            end else if (!Req[i] && ($urandom % 10) == 0) begin
               Req[i]              = 1'b1;
               Req_Data[i*DW +: DW] = DW'($urandom);
               Req_Par_En[i]       = 1'($urandom % 2);
            end else if (Req[i] && ($urandom % 80) == 0) begin
               Req[i] = 1'b0;
            end
         end
         tick(1);
      end
      RST = 1'b0;
      applyStimulus('0, '0, '0);
      tick(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
